instr_fetch_queue: RTL

// - Producer side of the decode interface: buffers raw fetched instruction words between fetch and decode.
// - Predecodes each word on entry: branch/jump class and delay-slot membership.
// - Decode pops {pc, instr, flags}. Decode never tracks delay slots itself.
// - Sits between the I-cache response path and the decode stage; flushed on redirect/exception.

---
 rtl/instr_fetch_queue_pkg.sv | 47 ++++
 rtl/instr_fetch_queue_if.sv | 30 +++
 rtl/instr_fetch_queue_predecode.sv | 14 +
 rtl/instr_fetch_queue.sv | 88 ++++++++
 4 files changed

// File: rtl/instr_fetch_queue_pkg.sv
// instr_fetch_queue_pkg: shared types, MIPS opcode constants and branch predecode helper
// Contents: word_t, fetch_entry_t, OP_/F_/B_ constants, is_branch_op()
package instr_fetch_queue_pkg;

    typedef logic [31:0] word_t;

    typedef struct packed {
        word_t pc;
        word_t instr;
        logic  adel;
        logic  is_branch;
        logic  in_delay_slot;
    } fetch_entry_t;

    localparam logic [5:0] OP_RT   = 6'h00;
    localparam logic [5:0] OP_BGEZ = 6'h01;
    localparam logic [5:0] OP_J    = 6'h02;
    localparam logic [5:0] OP_JAL  = 6'h03;
    localparam logic [5:0] OP_BEQ  = 6'h04;
    localparam logic [5:0] OP_BNE  = 6'h05;
    localparam logic [5:0] OP_BLEZ = 6'h06;
    localparam logic [5:0] OP_BGTZ = 6'h07;

    localparam logic [5:0] F_JR    = 6'h08;
    localparam logic [5:0] F_JALR  = 6'h09;

    localparam logic [4:0] B_BLTZ   = 5'h00;
    localparam logic [4:0] B_BGEZ   = 5'h01;
    localparam logic [4:0] B_BLTZAL = 5'h10;
    localparam logic [4:0] B_BGEZAL = 5'h11;

    // REGIMM only branches for the four listed rt codes; other rt values are traps etc.
    function automatic logic is_branch_op(word_t instr);
        logic [5:0] op;
        logic [4:0] rt;
        logic [5:0] fn;
        op = instr[31:26];
        rt = instr[20:16];
        fn = instr[5:0];
        return (op == OP_BEQ) || (op == OP_BNE) || (op == OP_BGTZ) || (op == OP_BLEZ) ||
               (op == OP_J) || (op == OP_JAL) ||
               ((op == OP_BGEZ) && ((rt == B_BGEZ) || (rt == B_BLTZ) ||
                                    (rt == B_BGEZAL) || (rt == B_BLTZAL))) ||
               ((op == OP_RT) && ((fn == F_JR) || (fn == F_JALR)));
    endfunction

endpackage

// File: rtl/instr_fetch_queue_if.sv
// instr_fetch_queue_if: fetch-side push and decode-side pop handshakes of the fetch queue
// master: fetch/decode environment (drives in_* payload, in_valid, out_ready)
// slave:  the queue (drives in_ready and all out_*)
interface instr_fetch_queue_if;
    import instr_fetch_queue_pkg::*;

    logic  in_valid;
    logic  in_ready;
    word_t in_pc;
    word_t in_instr;
    logic  in_adel;
    logic  out_valid;
    logic  out_ready;
    word_t out_pc;
    word_t out_instr;
    logic  out_adel;
    logic  out_is_branch;
    logic  out_in_delay_slot;

    modport master (
        output in_valid, in_pc, in_instr, in_adel, out_ready,
        input  in_ready, out_valid, out_pc, out_instr, out_adel, out_is_branch, out_in_delay_slot
    );

    modport slave (
        input  in_valid, in_pc, in_instr, in_adel, out_ready,
        output in_ready, out_valid, out_pc, out_instr, out_adel, out_is_branch, out_in_delay_slot
    );

endinterface

// File: rtl/instr_fetch_queue_predecode.sv
// fetch_predecode: combinational branch/jump classification of an incoming word
// Ports: instr_i (raw word), adel_i (address error), is_branch_o (branch/jump, 0 on adel)
module fetch_predecode
    import instr_fetch_queue_pkg::*;
(
    input  word_t instr_i,
    input  logic  adel_i,
    output logic  is_branch_o
);

    // A faulted fetch returns garbage, so its bits must not look like a branch.
    assign is_branch_o = !adel_i && is_branch_op(instr_i);

endmodule

// File: rtl/instr_fetch_queue.sv
// instr_fetch_queue: show-ahead FIFO between I-cache response and decode with branch/delay-slot predecode
// Ports: clk, resetn (async active-low), flush (discard everything), bus (slave: push in_*, pop out_*),
//        count (registered occupancy, 0..DEPTH)
module instr_fetch_queue
    import instr_fetch_queue_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       resetn,
    input  logic                       flush,
    instr_fetch_queue_if.slave         bus,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    fetch_entry_t    mem_q [DEPTH];
    fetch_entry_t    head;
    logic [AW-1:0]   wr_q, wr_d, rd_q, rd_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            last_q, last_d;
    logic            br, full, empty, push, pop;

    fetch_predecode u_predecode (
        .instr_i     (bus.in_instr),
        .adel_i      (bus.in_adel),
        .is_branch_o (br)
    );

    assign full          = cnt_q == CW'(DEPTH);
    assign empty         = cnt_q == '0;
    // in_ready depends only on occupancy: a full queue never passes a push through a pop.
    assign bus.in_ready  = !full;
    assign bus.out_valid = !empty;
    assign push          = bus.in_valid && !full && !flush;
    assign pop           = !empty && bus.out_ready && !flush;
    assign count         = cnt_q;

    // Stale storage is masked so decode sees zeros whenever the queue is empty.
    assign head                  = empty ? '0 : mem_q[rd_q];
    assign bus.out_pc            = head.pc;
    assign bus.out_instr         = head.instr;
    assign bus.out_adel          = head.adel;
    assign bus.out_is_branch     = head.is_branch;
    assign bus.out_in_delay_slot = head.in_delay_slot;

    always_comb begin
        wr_d   = wr_q;
        rd_d   = rd_q;
        cnt_d  = cnt_q;
        last_d = last_q;
        if (flush) begin
            wr_d   = '0;
            rd_d   = '0;
            cnt_d  = '0;
            last_d = 1'b0;
        end else begin
            if (push) begin
                wr_d   = wr_q + 1'b1;
                last_d = br;
            end
            if (pop) rd_d = rd_q + 1'b1;
            cnt_d = cnt_q + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_q   <= '0;
            rd_q   <= '0;
            cnt_q  <= '0;
            last_q <= 1'b0;
        end else begin
            wr_q   <= wr_d;
            rd_q   <= rd_d;
            cnt_q  <= cnt_d;
            last_q <= last_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_q] <= '{pc: bus.in_pc, instr: bus.in_instr, adel: bus.in_adel,
                                   is_branch: br, in_delay_slot: last_q};
    end

endmodule
